elevator_call_scheduler: RTL

ELEVATOR_CALL_SCHEDULER -- requirements
Module: elevator_call_scheduler

---
 rtl/elevator_call_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/elevator_call_scheduler.sv
// Elevator call scheduler: synchronizes call buttons, keeps a pending-call bitmap and runs
// an up/down sweep FSM. Optional per-floor debounce is enabled with ELEVATOR_CALL_DEBOUNCE_EN.
module elevator_call_scheduler #(
  parameter int NUM_FLOORS      = 10,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [3:0]            current_floor,
  input  logic                  car_idle,
  output logic [3:0]            target_floor,
  output logic                  target_valid,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up
);

  typedef enum logic [1:0] {SCHED_IDLE, SWEEP_UP, SWEEP_DOWN} sched_state_t;

  if (NUM_FLOORS < 1 || NUM_FLOORS > 16 || DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("elevator_call_scheduler: unsupported NUM_FLOORS or DEBOUNCE_CYCLES");
  end

  logic [NUM_FLOORS-1:0] r_sync1, r_sync2;
  logic [NUM_FLOORS-1:0] w_level;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= call_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef ELEVATOR_CALL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [NUM_FLOORS-1:0][CNT_W-1:0] r_db_cnt;
  logic [NUM_FLOORS-1:0]            r_db_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db_cnt   <= '0;
      r_db_level <= '0;
    end else begin
      for (int f = 0; f < NUM_FLOORS; f++) begin
        if (r_sync2[f] == r_db_level[f]) begin
          r_db_cnt[f] <= '0;
        end else if (r_db_cnt[f] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_db_level[f] <= r_sync2[f];
          r_db_cnt[f]   <= '0;
        end else begin
          r_db_cnt[f] <= r_db_cnt[f] + 1'b1;
        end
      end
    end
  end

  assign w_level = r_db_level;
`else
  assign w_level = r_sync2;
`endif

  // A floor is armed only once its button has been seen released after the synchronizer has
  // flushed, so a button held through reset cannot register until it is pressed again.
  logic [1:0]            r_settle;
  logic [NUM_FLOORS-1:0] r_armed, r_level_d, r_pending;
  logic [NUM_FLOORS-1:0] w_rise, w_clr;
  logic                  w_cur_valid;
  logic [3:0]            w_cur_eff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_settle  <= '0;
      r_armed   <= '0;
      r_level_d <= '0;
      r_pending <= '0;
    end else begin
      if (!r_settle[1]) r_settle <= r_settle + 2'd1;
      if (r_settle[1])  r_armed  <= r_armed | ~r_sync2;
      r_level_d <= w_level;
      r_pending <= (r_pending | w_rise) & ~w_clr;
    end
  end

  assign w_rise      = w_level & ~r_level_d & r_armed;
  assign w_cur_valid = int'(current_floor) < NUM_FLOORS;
  assign w_cur_eff   = w_cur_valid ? current_floor : 4'(NUM_FLOORS - 1);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_clr = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      w_clr[f] = car_idle && w_cur_valid && (current_floor == 4'(f));
    end
  end

  // Nearest-call search relative to the (clamped) car position.
  logic       w_has_up, w_has_dn, w_any_above, w_any_below;
  logic [3:0] w_up_sel, w_dn_sel;

  always_comb begin
    w_has_up    = 1'b0;
    w_has_dn    = 1'b0;
    w_any_above = 1'b0;
    w_any_below = 1'b0;
    w_up_sel    = w_cur_eff;
    w_dn_sel    = w_cur_eff;
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      if (r_pending[f] && (4'(f) >= w_cur_eff)) begin
        w_has_up = 1'b1;
        w_up_sel = 4'(f);
      end
    end
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (r_pending[f] && (4'(f) <= w_cur_eff)) begin
        w_has_dn = 1'b1;
        w_dn_sel = 4'(f);
      end
      if (r_pending[f] && (4'(f) > w_cur_eff)) w_any_above = 1'b1;
      if (r_pending[f] && (4'(f) < w_cur_eff)) w_any_below = 1'b1;
    end
  end

  sched_state_t r_state, w_state_nxt;
  logic [3:0]   r_target, w_target_nxt;
  logic         r_target_vld, w_target_vld_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= SCHED_IDLE;
      r_target     <= '0;
      r_target_vld <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_target     <= w_target_nxt;
      r_target_vld <= w_target_vld_nxt;
    end
  end

  // Direction changes wait for a stopped car; the target tracks the state being entered.
  always_comb begin
    w_state_nxt      = r_state;
    w_target_nxt     = current_floor;
    w_target_vld_nxt = 1'b0;
    case (r_state)
      SCHED_IDLE: begin
        if (car_idle) begin
          if (w_any_above)      w_state_nxt = SWEEP_UP;
          else if (w_any_below) w_state_nxt = SWEEP_DOWN;
        end
      end
      SWEEP_UP: begin
        if (!w_has_up && car_idle) w_state_nxt = w_any_below ? SWEEP_DOWN : SCHED_IDLE;
      end
      SWEEP_DOWN: begin
        if (!w_has_dn && car_idle) w_state_nxt = w_any_above ? SWEEP_UP : SCHED_IDLE;
      end
      default: w_state_nxt = SCHED_IDLE;
    endcase

    if (w_state_nxt == SWEEP_UP && w_has_up) begin
      w_target_nxt     = w_up_sel;
      w_target_vld_nxt = 1'b1;
    end else if (w_state_nxt == SWEEP_DOWN && w_has_dn) begin
      w_target_nxt     = w_dn_sel;
      w_target_vld_nxt = 1'b1;
    end
  end

  assign pending      = r_pending;
  assign target_floor = r_target;
  assign target_valid = r_target_vld;
  assign dir_up       = (r_state == SWEEP_UP);

endmodule
